seg7_display_engine: RTL and testbench



---
 rtl/seg7_pkg.sv | 22 ++
 rtl/biu_slave.sv | 45 ++++
 rtl/seg7_decoder.sv | 40 ++++
 rtl/seg7_timebase.sv | 51 +++++
 rtl/seg7_display_engine.sv | 177 +++++++++++++++++
 tb/tb_seg7_display_engine.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display engine.
//   - register select codes (address bits [4:2] of the register window)
//   - reset constants for segments and brightness
//   - seg7_ctrl_t: layout of the CTRL register
package seg7_pkg;

    localparam logic [2:0] REG_DIGITS_LO = 3'd0;
    localparam logic [2:0] REG_DIGITS_HI = 3'd1;
    localparam logic [2:0] REG_CTRL      = 3'd2;
    localparam logic [2:0] REG_DP        = 3'd3;
    localparam logic [2:0] REG_BRIGHT    = 3'd4;
    localparam logic [2:0] REG_STATUS    = 3'd5;

    localparam logic [6:0] SEG_OFF    = 7'h7f;  // all segments dark (active-low)
    localparam logic [3:0] BRIGHT_RST = 4'hf;   // full brightness

    typedef struct packed {
        logic [15:0] blink_mask;
        logic [15:0] enable;
    } seg7_ctrl_t;

endpackage

// File: rtl/biu_slave.sv
// Bus interface unit for a memory-mapped slave.
// Decodes a window of ADDR_SPAN bytes at BASE_ADDR on the shared bus and
// presents a simple register-port to the slave logic.
//   bus_address  inout  shared address (only observed)
//   bus_data     inout  shared data; driven only while returning read data
//   bus_control  inout  [1] cycle request, [0] read-not-write (only observed)
//   o_address    out    byte offset inside the window
//   o_data       out    write data
//   en / rnw     out    access to this window / direction
//   i_data       in     read data from the slave
//   i_data_valid in     slave has read data for this cycle
module biu_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hc0001000,
    parameter int                    ADDR_SPAN  = 32,
    parameter int                    ALIGNED    = 1,
    localparam int                   OFF_W      = $clog2(ADDR_SPAN)
) (
    inout  wire  [ADDR_WIDTH-1:0] bus_address,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    inout  wire  [1:0]            bus_control,
    output logic [OFF_W-1:0]      o_address,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  en,
    output logic                  rnw,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid
);

    logic hit;
    logic aligned_ok;

    // Window is span-aligned, so matching the upper bits is enough.
    assign hit        = bus_address[ADDR_WIDTH-1:OFF_W] == BASE_ADDR[ADDR_WIDTH-1:OFF_W];
    assign aligned_ok = (ALIGNED == 0) || (bus_address[1:0] == 2'b00);

    assign en        = bus_control[1] && hit && aligned_ok;
    assign rnw       = bus_control[0];
    assign o_address = bus_address[OFF_W-1:0];
    assign o_data    = bus_data;

    assign bus_data = (en && rnw && i_data_valid) ? i_data : 'z;

endmodule

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low 7-segment pattern (bit order gfedcba).
//   n_rst   in   blanks the pattern while low
//   nibble  in   hex value
//   o_seg   out  segment pattern, 0 = lit
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic       n_rst,
    input  logic [3:0] nibble,
    output logic [6:0] o_seg
);

    logic [6:0] pat;

    always_comb begin
        pat = SEG_OFF;
        case (nibble)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'ha: pat = 7'h08;
            4'hb: pat = 7'h03;
            4'hc: pat = 7'h46;
            4'hd: pat = 7'h21;
            4'he: pat = 7'h06;
            4'hf: pat = 7'h0e;
            default: pat = SEG_OFF;
        endcase
    end

    assign o_seg = n_rst ? pat : SEG_OFF;

endmodule

// File: rtl/seg7_timebase.sv
// Free-running timers for the display engine.
//   clk, n_rst   in   clock, synchronous active-low reset
//   pwm_cnt      out  16-step PWM phase, advances every PWM_DIV clocks
//   blink_phase  out  toggles every BLINK_DIV clocks
//   frame_cnt    out  full blink periods seen (counts 1->0 phase edges), wraps
module seg7_timebase #(
    parameter int PWM_DIV   = 64,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        n_rst,
    output logic [3:0]  pwm_cnt,
    output logic        blink_phase,
    output logic [15:0] frame_cnt
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0] pwm_pre;
    logic [BW-1:0] blink_ctr;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pwm_pre     <= '0;
            pwm_cnt     <= '0;
            blink_ctr   <= '0;
            blink_phase <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (pwm_pre == PWM_LAST) begin
                pwm_pre <= '0;
                pwm_cnt <= pwm_cnt + 4'd1;
            end else begin
                pwm_pre <= pwm_pre + PW'(1);
            end

            if (blink_ctr == BLINK_LAST) begin
                blink_ctr   <= '0;
                blink_phase <= ~blink_phase;
                if (blink_phase)
                    frame_cnt <= frame_cnt + 16'd1;
            end else begin
                blink_ctr <= blink_ctr + BW'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_display_engine.sv
// Memory-mapped 7-segment display engine (up to 16 digits).
// Digit values, enables, blink mask, decimal points and a 16-level PWM
// brightness are programmed over the system bus; a read-only STATUS word
// exposes the blink phase and a blink-period frame counter.
//   clk, n_rst    in     clock, synchronous active-low reset
//   bus_address   inout  system bus address
//   bus_data      inout  system bus data
//   bus_control   inout  system bus control
//   o_hex[i]      out    active-low segments of digit i (registered)
//   o_dp[i]       out    active-low decimal point of digit i (registered)
module seg7_display_engine
    import seg7_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'hc0001000,
    parameter int                    NUM_7SEGMENTS = 8,
    parameter int                    PWM_DIV       = 64,
    parameter int                    BLINK_DIV     = 25000000
) (
    input  logic                     clk,
    input  logic                     n_rst,
    inout  wire  [ADDR_WIDTH-1:0]    bus_address,
    inout  wire  [DATA_WIDTH-1:0]    bus_data,
    inout  wire  [1:0]               bus_control,
    output logic [6:0]               o_hex [0:NUM_7SEGMENTS-1],
    output logic [NUM_7SEGMENTS-1:0] o_dp
);

    localparam int N = NUM_7SEGMENTS;

    logic [4:0]            addr_off;
    logic [2:0]            reg_sel;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  en;
    logic                  rnw;
    logic                  wr;
    logic                  unused_addr;

    // Only implemented digits get storage; everything above N reads 0.
    logic [N-1:0][3:0] digits;
    logic [N-1:0]      digit_en;
    logic [N-1:0]      blink_mask;
    logic [N-1:0]      dp_on;
    logic [3:0]        bright;

    logic [3:0]        pwm_cnt;
    logic              blink_phase;
    logic [15:0]       frame_cnt;

    logic [31:0]       digits_lo;
    logic [31:0]       digits_hi;
    seg7_ctrl_t        ctrl_rd;
    logic              pwm_on;
    logic [N-1:0]      lit;
    logic [N-1:0][6:0] dec_seg;

    biu_slave #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .BASE_ADDR    (BASE_ADDR),
        .ADDR_SPAN    (32),
        .ALIGNED      (1)
    ) u_biu (
        .bus_address  (bus_address),
        .bus_data     (bus_data),
        .bus_control  (bus_control),
        .o_address    (addr_off),
        .o_data       (wdata),
        .en           (en),
        .rnw          (rnw),
        .i_data       (rdata),
        .i_data_valid (en && rnw)
    );

    assign reg_sel     = addr_off[4:2];
    assign unused_addr = ^addr_off[1:0];
    assign wr          = en && !rnw;

    seg7_timebase #(
        .PWM_DIV     (PWM_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) u_timebase (
        .clk         (clk),
        .n_rst       (n_rst),
        .pwm_cnt     (pwm_cnt),
        .blink_phase (blink_phase),
        .frame_cnt   (frame_cnt)
    );

    // ---------------- register file ----------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            digits     <= '0;
            digit_en   <= '1;
            blink_mask <= '0;
            dp_on      <= '0;
            bright     <= BRIGHT_RST;
        end else if (wr) begin
            case (reg_sel)
                REG_DIGITS_LO, REG_DIGITS_HI: begin
                    // Digits 0-7 live in DIGITS_LO, 8-15 in DIGITS_HI.
                    for (int i = 0; i < N; i++)
                        if ((i < 8) == (reg_sel == REG_DIGITS_LO))
                            digits[i] <= wdata[4*(i%8) +: 4];
                end
                REG_CTRL: begin
                    digit_en   <= wdata[N-1:0];
                    blink_mask <= wdata[16 +: N];
                end
                REG_DP:     dp_on  <= wdata[N-1:0];
                REG_BRIGHT: bright <= wdata[3:0];
                default: ;  // STATUS and reserved offsets are read-only
            endcase
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        digits_lo = '0;
        digits_hi = '0;
        for (int i = 0; i < N; i++) begin
            if (i < 8) digits_lo[4*(i%8) +: 4] = digits[i];
            else       digits_hi[4*(i%8) +: 4] = digits[i];
        end
    end

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd.enable[N-1:0]     = digit_en;
        ctrl_rd.blink_mask[N-1:0] = blink_mask;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DIGITS_LO: rdata = digits_lo;
            REG_DIGITS_HI: rdata = digits_hi;
            REG_CTRL:      rdata = ctrl_rd;
            REG_DP:        rdata = 32'(dp_on);
            REG_BRIGHT:    rdata = {28'd0, bright};
            REG_STATUS:    rdata = {frame_cnt, 15'd0, blink_phase};
            default:       rdata = '0;
        endcase
    end

    // ---------------- display path ----------------
    for (genvar g = 0; g < N; g++) begin : g_dec
        seg7_decoder u_dec (
            .n_rst  (n_rst),
            .nibble (digits[g]),
            .o_seg  (dec_seg[g])
        );
    end

    // Level 15 bypasses the PWM so full brightness never flickers.
    always_comb begin
        pwm_on = (bright == 4'hf) || (pwm_cnt < bright);
        for (int i = 0; i < N; i++)
            lit[i] = digit_en[i] && pwm_on && !(blink_mask[i] && blink_phase);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < N; i++)
                o_hex[i] <= SEG_OFF;
            o_dp <= '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                o_hex[i] <= lit[i] ? dec_seg[i] : SEG_OFF;
                o_dp[i]  <= ~(lit[i] & dp_on[i]);
            end
        end
    end

endmodule

// File: tb/tb_seg7_display_engine.sv
module tb_seg7_display_engine;

    localparam logic [31:0] B8   = 32'hc0001000;  // 8-digit instance
    localparam logic [31:0] B4   = 32'hc0001020;  // 4-digit instance
    localparam int          BDIV = 8;
    localparam logic [6:0]  SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    logic [31:0] drv_addr = '0;
    logic [31:0] drv_data = '0;
    logic        drv_en   = 1'b0;
    logic [1:0]  drv_ctrl = 2'b00;

    wire [31:0] bus_address;
    wire [31:0] bus_data;
    wire [1:0]  bus_control;

    assign bus_address = drv_addr;
    assign bus_control = drv_ctrl;
    assign bus_data    = drv_en ? drv_data : 'z;

    logic [6:0] hex8 [0:7];
    logic [7:0] dp8;
    logic [6:0] hex4 [0:3];
    logic [3:0] dp4;
    logic       unused_dut4;
    assign unused_dut4 = ^{dp4, hex4[0], hex4[1], hex4[2], hex4[3]};

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seg7_display_engine #(
        .BASE_ADDR(B8), .NUM_7SEGMENTS(8), .PWM_DIV(1), .BLINK_DIV(BDIV)
    ) dut (
        .clk(clk), .n_rst(n_rst), .bus_address(bus_address), .bus_data(bus_data),
        .bus_control(bus_control), .o_hex(hex8), .o_dp(dp8)
    );

    seg7_display_engine #(
        .BASE_ADDR(B4), .NUM_7SEGMENTS(4), .PWM_DIV(1), .BLINK_DIV(BDIV)
    ) dut4 (
        .clk(clk), .n_rst(n_rst), .bus_address(bus_address), .bus_data(bus_data),
        .bus_control(bus_control), .o_hex(hex4), .o_dp(dp4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k = clock edges since reset release; with PWM_DIV=1 the PWM step is
    // k mod 16, the blink phase is (k / BDIV) mod 2 and a frame is 2*BDIV.
    int         k = 0;
    logic [3:0] m_dig [8];
    logic [7:0] m_en, m_blink, m_dp;
    logic [3:0] m_br;
    logic [6:0] exp_hex [8];
    logic [7:0] exp_dp;
    bit         have_exp = 0;

    function automatic logic [31:0] exp_status(input int kk);
        return {16'(kk / (2*BDIV)), 15'd0, 1'((kk / BDIV) % 2)};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (have_exp) begin
                for (int i = 0; i < 8; i++)
                    chk($sformatf("model_hex%0d", i), 32'(hex8[i]), 32'(exp_hex[i]));
                chk("model_dp", 32'(dp8), 32'(exp_dp));
            end
            if (!n_rst) begin
                for (int i = 0; i < 8; i++) begin
                    exp_hex[i] = 7'h7f;
                    m_dig[i]   = 4'h0;
                end
                exp_dp  = 8'hff;
                m_en    = 8'hff;
                m_blink = 8'h00;
                m_dp    = 8'h00;
                m_br    = 4'hf;
                k       = 0;
            end else begin
                int  pwm;
                bit  phase, pwm_on, lit;
                pwm    = k % 16;
                phase  = ((k / BDIV) % 2) == 1;
                pwm_on = (m_br == 4'hf) || (pwm < int'(m_br));
                for (int i = 0; i < 8; i++) begin
                    lit        = m_en[i] && pwm_on && !(m_blink[i] && phase);
                    exp_hex[i] = lit ? SEG_TAB[m_dig[i]] : 7'h7f;
                    exp_dp[i]  = !(lit && m_dp[i]);
                end
                if (drv_ctrl == 2'b10 && drv_addr[31:5] == B8[31:5]) begin
                    case (drv_addr[4:0])
                        5'h00: for (int i = 0; i < 8; i++) m_dig[i] = drv_data[4*i +: 4];
                        5'h08: begin m_en = drv_data[7:0]; m_blink = drv_data[23:16]; end
                        5'h0c: m_dp = drv_data[7:0];
                        5'h10: m_br = drv_data[3:0];
                        default: ;
                    endcase
                end
                k++;
            end
            have_exp = 1;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #2 drv_addr = a; drv_data = d; drv_en = 1'b1; drv_ctrl = 2'b10;
        @(posedge clk);
        #2 drv_ctrl = 2'b00; drv_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input bit use_status,
                          input logic [31:0] exp);
        logic [31:0] d;
        @(posedge clk);
        #2 drv_addr = a; drv_ctrl = 2'b11; drv_en = 1'b0;
        #2 d = bus_data;
        chk(name, d, use_status ? exp_status(k) : exp);
        #2 drv_ctrl = 2'b00;
    endtask

    task automatic count_lit(input int digit, output int cnt);
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #4 if (hex8[digit] != 7'h7f) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;

        // 1. reset state
        @(posedge clk);
        #4 chk("first_post_reset_hex0", 32'(hex8[0]), 32'h40);
        chk("first_post_reset_dp", 32'(dp8), 32'hff);
        rd_chk("rst_digits_lo", B8 + 32'h00, 0, 32'h0);
        rd_chk("rst_digits_hi", B8 + 32'h04, 0, 32'h0);
        rd_chk("rst_ctrl",      B8 + 32'h08, 0, 32'h0000_00ff);
        rd_chk("rst_dp",        B8 + 32'h0c, 0, 32'h0);
        rd_chk("rst_bright",    B8 + 32'h10, 0, 32'hf);
        rd_chk("rst_status",    B8 + 32'h14, 1, 32'h0);
        rd_chk("rsvd_18",       B8 + 32'h18, 0, 32'h0);
        rd_chk("rsvd_1c",       B8 + 32'h1c, 0, 32'h0);
        rd_chk("rst_ctrl4",     B4 + 32'h08, 0, 32'h0000_000f);
        while (k < 47) @(posedge clk);
        rd_chk("frame_at_48", B8 + 32'h14, 0, 32'h0003_0000);

        // 2. digits and decimal points
        wr(B8 + 32'h00, 32'h7654_3210);
        wr(B8 + 32'h0c, 32'h0000_0005);
        @(posedge clk);
        #4 chk("digit3_pattern", 32'(hex8[3]), 32'h30);
        chk("dp_pattern", 32'(dp8), 32'hfa);
        rd_chk("rb_digits_lo", B8 + 32'h00, 0, 32'h7654_3210);
        rd_chk("rb_dp",        B8 + 32'h0c, 0, 32'h5);

        // 3. brightness
        wr(B8 + 32'h10, 32'h0000_00f4);
        rd_chk("rb_bright", B8 + 32'h10, 0, 32'h4);
        count_lit(0, cnt); chk("bright4_lit", 32'(cnt), 32'd4);
        wr(B8 + 32'h10, 32'h0);
        count_lit(0, cnt); chk("bright0_lit", 32'(cnt), 32'd0);
        wr(B8 + 32'h10, 32'hf);
        count_lit(0, cnt); chk("bright15_lit", 32'(cnt), 32'd16);

        // 4. enables and blink
        wr(B8 + 32'h08, 32'h0001_00fe);
        count_lit(0, cnt); chk("dis_digit0_lit", 32'(cnt), 32'd0);
        count_lit(1, cnt); chk("steady_digit1_lit", 32'(cnt), 32'd16);
        wr(B8 + 32'h08, 32'h0002_00ff);
        count_lit(1, cnt); chk("blink_digit1_lit", 32'(cnt), 32'd8);
        rd_chk("status_mid", B8 + 32'h14, 1, 32'h0);

        // 5. narrow instance and read-only/reserved offsets
        wr(B4 + 32'h04, 32'hffff_ffff); rd_chk("n4_digits_hi", B4 + 32'h04, 0, 32'h0);
        wr(B4 + 32'h08, 32'hffff_ffff); rd_chk("n4_ctrl",      B4 + 32'h08, 0, 32'h000f_000f);
        wr(B4 + 32'h00, 32'hffff_ffff); rd_chk("n4_digits_lo", B4 + 32'h00, 0, 32'h0000_ffff);
        wr(B4 + 32'h10, 32'h0000_00ff); rd_chk("n4_bright",    B4 + 32'h10, 0, 32'hf);
        wr(B4 + 32'h1c, 32'hffff_ffff); rd_chk("n4_rsvd_1c",   B4 + 32'h1c, 0, 32'h0);
        wr(B4 + 32'h14, 32'hffff_ffff); rd_chk("n4_status",    B4 + 32'h14, 1, 32'h0);
        wr(B8 + 32'h04, 32'hffff_ffff); rd_chk("n8_digits_hi", B8 + 32'h04, 0, 32'h0);

        // 6. reset mid-blink, coinciding with a write
        wr(B8 + 32'h10, 32'h3);
        repeat (5) @(posedge clk);
        #2 n_rst = 1'b0;
        drv_addr = B8; drv_data = 32'hdead_beef; drv_en = 1'b1; drv_ctrl = 2'b10;
        @(posedge clk);
        #2 n_rst = 1'b1; drv_ctrl = 2'b00; drv_en = 1'b0;
        #2 chk("rst_mid_hex2", 32'(hex8[2]), 32'h7f);
        chk("rst_mid_dp", 32'(dp8), 32'hff);
        rd_chk("rst2_status",    B8 + 32'h14, 0, 32'h0);
        rd_chk("rst2_digits_lo", B8 + 32'h00, 0, 32'h0);
        rd_chk("rst2_ctrl",      B8 + 32'h08, 0, 32'h0000_00ff);
        rd_chk("rst2_dp",        B8 + 32'h0c, 0, 32'h0);
        rd_chk("rst2_bright",    B8 + 32'h10, 0, 32'hf);
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
